// File: rtl/baud_gen_frac.sv
// Fractional-N baud generator.
// A phase accumulator overflows at OVERSAMPLE x baud. Each overflow advances the
// oversample counter, which produces the mid-bit tick, the bit-boundary tick and
// a 50%-duty clk_out. A new increment can be loaded at runtime through
// valid/ready. While running, a new increment is held back until the next bit
// boundary so the current bit is never stretched or shortened.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | en_in low; an accepted increment is applied on the next edge
// RUN   | generating ticks; an accepted increment is parked in inc_pend
// PEND  | waiting for a bit boundary (or resync) to apply inc_pend
module baud_gen_frac #(
  parameter int          ACC_W       = 24,
  parameter int          OVERSAMPLE  = 16,
  parameter int unsigned DEFAULT_INC = 309238
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             en_in,
  input  logic             resync_in,
  input  logic [ACC_W-1:0] inc_in,
  input  logic             cfg_valid_in,
  output logic             cfg_ready_out,
  output logic             cfg_err_out,
  output logic             tick_os_out,
  output logic             tick_mid_out,
  output logic             tick_baud_out,
  output logic             clk_out
);

  localparam int              OS_W    = $clog2(OVERSAMPLE);
  localparam logic [OS_W-1:0] OS_HALF = OS_W'(OVERSAMPLE / 2);
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_PEND = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q;
  logic [OS_W-1:0]    os_cnt_q;
  logic [ACC_W-1:0]   inc_act_q, inc_act_d;
  logic [ACC_W-1:0]   inc_pend_q, inc_pend_d;
  logic               err_q;

  logic [ACC_W:0]     sum;
  logic               carry;
  logic [OS_W-1:0]    os_next;
  logic               step;
  logic               bit_edge;
  logic               accept;
  logic               inc_ok;
  logic               inc_zero;

  assign cfg_ready_out = (state_q != S_PEND);
  assign cfg_err_out   = err_q;

  // Phase step, carry and the handshake qualifiers shared by FSM and datapath.
  always_comb begin
    sum      = {1'b0, acc_q} + {1'b0, inc_act_q};
    carry    = sum[ACC_W];
    os_next  = os_cnt_q + 1'b1;
    step     = en_in & ~resync_in;
    // The edge that produces tick_baud_out; it still runs on the old increment.
    bit_edge = step & carry & (os_cnt_q == OS_LAST);
    accept   = cfg_valid_in & cfg_ready_out;
    inc_zero = (inc_in == '0);
    inc_ok   = accept & ~inc_zero;
  end

  // Config FSM: next state and increment bookkeeping.
  always_comb begin
    state_d    = state_q;
    inc_act_d  = inc_act_q;
    inc_pend_d = inc_pend_q;
    case (state_q)
      S_IDLE: begin
        if (inc_ok) inc_act_d = inc_in;
        if (en_in) state_d = S_RUN;
      end
      S_RUN: begin
        if (inc_ok) begin
          // A resync or a drop to IDLE on the same edge is a safe point to apply at once.
          if (resync_in || !en_in) begin
            inc_act_d = inc_in;
          end else begin
            inc_pend_d = inc_in;
            state_d    = S_PEND;
          end
        end
        if (!en_in) state_d = S_IDLE;
      end
      S_PEND: begin
        if (!en_in || resync_in || bit_edge) begin
          inc_act_d = inc_pend_q;
          state_d   = en_in ? S_RUN : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Config state, active/pending increments and the reject pulse.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= S_IDLE;
      inc_act_q  <= ACC_W'(DEFAULT_INC);
      inc_pend_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      inc_act_q  <= inc_act_d;
      inc_pend_q <= inc_pend_d;
      err_q      <= accept & inc_zero;
    end
  end

  // Phase accumulator, oversample counter, ticks and clk_out.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      acc_q         <= '0;
      os_cnt_q      <= '0;
      tick_os_out   <= 1'b0;
      tick_mid_out  <= 1'b0;
      tick_baud_out <= 1'b0;
      clk_out       <= 1'b0;
    end else if (resync_in) begin
      acc_q         <= '0;
      os_cnt_q      <= '0;
      tick_os_out   <= 1'b0;
      tick_mid_out  <= 1'b0;
      tick_baud_out <= 1'b0;
      clk_out       <= 1'b1;
    end else if (en_in) begin
      acc_q         <= sum[ACC_W-1:0];
      tick_os_out   <= carry;
      tick_mid_out  <= carry & (os_next == OS_HALF);
      tick_baud_out <= carry & (os_next == '0);
      if (carry) begin
        os_cnt_q <= os_next;
        if (os_next == '0) begin
          clk_out <= 1'b1;
        end else if (os_next == OS_HALF) begin
          clk_out <= 1'b0;
        end
      end
    end else begin
      tick_os_out   <= 1'b0;
      tick_mid_out  <= 1'b0;
      tick_baud_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_baud_gen_frac.sv
// Bench for baud_gen_frac: directed stimulus pushes expected tick cycles into
// queues; a negedge monitor pops and compares whenever a tick appears.
module tb_baud_gen_frac;

  localparam int ACC_W = 24;

  logic             clk_in = 1'b0;
  logic             rst_n_in;
  logic             en_in;
  logic             resync_in;
  logic [ACC_W-1:0] inc_in;
  logic             cfg_valid_in;
  logic             cfg_ready_out;
  logic             cfg_err_out;
  logic             tick_os_out;
  logic             tick_mid_out;
  logic             tick_baud_out;
  logic             clk_out;

  int     total = 0;
  int     bad   = 0;
  longint cyc   = 0;
  bit     track = 1'b0;
  int     n_baud = 0;
  int     n_os   = 0;
  longint baud_q[$];
  longint mid_q[$];
  longint err_q[$];

  baud_gen_frac dut (
    .clk_in        (clk_in),
    .rst_n_in      (rst_n_in),
    .en_in         (en_in),
    .resync_in     (resync_in),
    .inc_in        (inc_in),
    .cfg_valid_in  (cfg_valid_in),
    .cfg_ready_out (cfg_ready_out),
    .cfg_err_out   (cfg_err_out),
    .tick_os_out   (tick_os_out),
    .tick_mid_out  (tick_mid_out),
    .tick_baud_out (tick_baud_out),
    .clk_out       (clk_out)
  );

  always #5 clk_in = ~clk_in;

  // Cycle index: value seen at a negedge equals the number of posedges so far.
  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_rng(input string name, input longint act, input longint lo, input longint hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic step_to(input longint t);
    while (cyc < t) @(negedge clk_in);
  endtask

  // Monitor: counts ticks and, when tracking, matches each tick to its expected cycle.
  always @(negedge clk_in) begin
    if (rst_n_in) begin
      if (tick_baud_out) n_baud++;
      if (tick_os_out) n_os++;
      if (track) begin
        if (tick_baud_out) begin
          if (baud_q.size() == 0) chk("baud_unexpected", cyc, -1);
          else chk("baud_time", cyc, baud_q.pop_front());
        end else if (baud_q.size() > 0 && baud_q[0] < cyc) begin
          chk("baud_missed", -1, baud_q.pop_front());
        end
        if (tick_mid_out) begin
          if (mid_q.size() == 0) chk("mid_unexpected", cyc, -1);
          else chk("mid_time", cyc, mid_q.pop_front());
        end else if (mid_q.size() > 0 && mid_q[0] < cyc) begin
          chk("mid_missed", -1, mid_q.pop_front());
        end
        if (cfg_err_out) begin
          if (err_q.size() == 0) chk("err_unexpected", cyc, -1);
          else chk("err_time", cyc, err_q.pop_front());
        end else if (err_q.size() > 0 && err_q[0] < cyc) begin
          chk("err_missed", -1, err_q.pop_front());
        end
      end
    end
  end

  // Directed stimulus.
  initial begin
    longint k, r, c, s, b;
    rst_n_in = 1'b0; en_in = 1'b0; resync_in = 1'b0; cfg_valid_in = 1'b0; inc_in = '0;
    repeat (3) @(negedge clk_in);
    chk("rst_ready", cfg_ready_out, 1);
    chk("rst_clk_out", clk_out, 0);
    chk("rst_tick_os", tick_os_out, 0);
    chk("rst_tick_baud", tick_baud_out, 0);
    chk("rst_err", cfg_err_out, 0);
    rst_n_in = 1'b1;
    @(negedge clk_in);

    // Mid-run reset with a pending config that must be discarded.
    en_in = 1'b1;
    repeat (200) @(negedge clk_in);
    resync_in = 1'b1;
    @(negedge clk_in);
    resync_in = 1'b0;
    chk("resync_clk_out", clk_out, 1);
    cfg_valid_in = 1'b1; inc_in = 24'h400000;
    @(negedge clk_in);
    cfg_valid_in = 1'b0; inc_in = '0;
    chk("pend_ready", cfg_ready_out, 0);
    #2 rst_n_in = 1'b0; en_in = 1'b0;
    #1;
    chk("async_ready", cfg_ready_out, 1);
    chk("async_clk_out", clk_out, 0);
    chk("async_tick_os", tick_os_out, 0);
    chk("async_tick_mid", tick_mid_out, 0);
    chk("async_tick_baud", tick_baud_out, 0);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    @(negedge clk_in);

    // Default rate over 30000 enabled edges: 552 os ticks, 34 bit ticks.
    n_baud = 0; n_os = 0;
    k = cyc;
    en_in = 1'b1;
    step_to(k + 30000);
    en_in = 1'b0;
    @(negedge clk_in);
    chk_rng("default_os_count", n_os, 551, 553);
    chk_rng("default_baud_count", n_baud, 33, 35);

    // Exact rate 0x400000 loaded in IDLE, then resync + enable.
    chk("idle_ready", cfg_ready_out, 1);
    cfg_valid_in = 1'b1; inc_in = 24'h400000;
    @(negedge clk_in);
    cfg_valid_in = 1'b0; inc_in = '0;
    track = 1'b1;
    r = cyc + 1;
    resync_in = 1'b1; en_in = 1'b1;
    for (int j = 0; j < 3; j++) begin
      mid_q.push_back(r + 32 + 64 * j);
      baud_q.push_back(r + 64 * (j + 1));
    end
    for (int i = 0; i < 192; i++) begin
      @(negedge clk_in);
      resync_in = 1'b0;
      chk("clk_out_shape", clk_out, ((cyc - r) % 64) < 32);
      chk("tick_os_spacing", tick_os_out, ((cyc - r) % 4 == 0) && (cyc != r));
    end

    // Freeze for 10 cycles, then resync at os_cnt=11.
    c = r + 192;
    mid_q.push_back(c + 32);
    baud_q.push_back(c + 74);
    mid_q.push_back(c + 106);
    step_to(c + 40);
    en_in = 1'b0;
    for (int i = 41; i <= 50; i++) begin
      step_to(c + i);
      chk("freeze_tick_os", tick_os_out, 0);
    end
    en_in = 1'b1;
    step_to(c + 119);
    chk("pre_resync_clk_out", clk_out, 0);
    s = c + 120;
    mid_q.push_back(s + 32);
    baud_q.push_back(s + 64);
    mid_q.push_back(s + 96);
    baud_q.push_back(s + 128);
    resync_in = 1'b1;
    @(negedge clk_in);
    resync_in = 1'b0;
    chk("resync2_clk_out", clk_out, 1);

    // Reload 0x200000 at os_cnt=5: current bit finishes at 64, next bits take 128.
    b = s + 128;
    step_to(b + 21);
    chk("reload_ready_before", cfg_ready_out, 1);
    cfg_valid_in = 1'b1; inc_in = 24'h200000;
    @(negedge clk_in);
    cfg_valid_in = 1'b0; inc_in = '0;
    chk("reload_ready_low", cfg_ready_out, 0);
    mid_q.push_back(b + 32);
    baud_q.push_back(b + 64);
    mid_q.push_back(b + 128);
    baud_q.push_back(b + 192);
    mid_q.push_back(b + 256);
    baud_q.push_back(b + 320);
    step_to(b + 29);
    cfg_valid_in = 1'b1; inc_in = 24'h100000;
    @(negedge clk_in);
    cfg_valid_in = 1'b0; inc_in = '0;
    step_to(b + 63);
    chk("pend_ready_hold", cfg_ready_out, 0);
    step_to(b + 64);
    chk("ready_after_boundary", cfg_ready_out, 1);

    // Zero increment is rejected with a one-cycle error pulse, rate and state kept.
    step_to(b + 340);
    chk("zero_ready_before", cfg_ready_out, 1);
    err_q.push_back(b + 341);
    mid_q.push_back(b + 384);
    baud_q.push_back(b + 448);
    cfg_valid_in = 1'b1; inc_in = '0;
    @(negedge clk_in);
    cfg_valid_in = 1'b0;
    chk("zero_ready_after", cfg_ready_out, 1);
    step_to(b + 460);

    chk("baud_left", baud_q.size(), 0);
    chk("mid_left", mid_q.size(), 0);
    chk("err_left", err_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
